// File: rtl/seq_comparator_if.sv
// Request/result handshake bundle for seq_comparator: operands and funct3 in, taken/latency out.
// Both directions use valid/ready flow control; the master side is the requester.
interface seq_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
);
  localparam int LAT_W = $clog2(WIDTH / CHUNK + 1);

  logic             start_valid;
  logic             start_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done_valid;
  logic             done_ready;
  logic             taken;
  logic [LAT_W-1:0] latency;

  modport master (
    output start_valid, funct3, a, b, done_ready,
    input  start_ready, done_valid, taken, latency
  );

  modport slave (
    input  start_valid, funct3, a, b, done_ready,
    output start_ready, done_valid, taken, latency
  );
endinterface

// File: rtl/seq_comparator.sv
// Multi-cycle RISC-V branch comparator scanning CHUNK bits per cycle MSB-first; 1..N BUSY cycles.
// Accepts only in IDLE; holds taken/latency in DONE until done_ready, so results are never dropped.
module seq_comparator #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  seq_comparator_if.slave    bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int LAT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       f3_q;
  logic             eq_q, lt_q;
  logic [IDX_W-1:0] idx_q;
  logic [LAT_W-1:0] cnt_q;
  logic             taken_q;
  logic [LAT_W-1:0] lat_q;

  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             eq_nxt, lt_nxt, last_chunk, taken_nxt;
  logic [WIDTH-1:0] sign_mask;

  // Flipping the sign bit of both operands maps signed order onto unsigned order.
  always_comb begin
    sign_mask            = '0;
    sign_mask[WIDTH-1]   = (bus.funct3[2:1] == 2'b10);
  end

  always_comb begin
    chunk_a    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    chunk_b    = b_q[int'(idx_q) * CHUNK +: CHUNK];
    eq_nxt     = eq_q && (chunk_a == chunk_b);
    lt_nxt     = lt_q || (eq_q && (chunk_a < chunk_b));
    last_chunk = (idx_q == '0) || ((EARLY_EXIT != 0) && eq_q && (chunk_a != chunk_b));
    case (f3_q)
      3'b000:          taken_nxt = eq_nxt;
      3'b001:          taken_nxt = !eq_nxt;
      3'b100, 3'b110:  taken_nxt = lt_nxt;
      3'b101, 3'b111:  taken_nxt = !lt_nxt;
      default:         taken_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.start_ready = 1'b0;
    bus.done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        bus.done_valid = 1'b1;
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.taken   = taken_q;
  assign bus.latency = lat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      taken_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_valid) begin
          a_q   <= bus.a ^ sign_mask;
          b_q   <= bus.b ^ sign_mask;
          f3_q  <= bus.funct3;
          eq_q  <= 1'b1;
          lt_q  <= 1'b0;
          idx_q <= IDX_W'(N - 1);
          cnt_q <= '0;
        end
        BUSY: begin
          eq_q  <= eq_nxt;
          lt_q  <= lt_nxt;
          cnt_q <= cnt_q + LAT_W'(1);
          if (last_chunk) begin
            taken_q <= taken_nxt;
            lat_q   <= cnt_q + LAT_W'(1);
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: early-exit instance (u0) and full-scan instance (u1).
module tb_seq_comparator;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_comparator_if #(.WIDTH(32), .CHUNK(8)) if0 ();
  seq_comparator_if #(.WIDTH(32), .CHUNK(8)) if1 ();

  seq_comparator #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  seq_comparator #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_taken;
    int          exp_lat;
  } vec_t;

  vec_t v0[12];
  vec_t v1[3];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if0.funct3 = f3; if0.a = a; if0.b = b;
    if1.funct3 = f3; if1.a = a; if1.b = b;
  endtask

  // Called just after an edge with the target idle. cyc = edges after the accepting edge
  // until done_valid is seen, which equals the number of BUSY cycles.
  task automatic issue(input bit sel, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic t, output int lat, output int cyc);
    drive(f3, a, b);
    if (sel) if1.start_valid = 1'b1; else if0.start_valid = 1'b1;
    chk("start_ready_before_accept", sel ? if1.start_ready : if0.start_ready, 1);
    @(posedge clk); #1;
    if0.start_valid = 1'b0;
    if1.start_valid = 1'b0;
    drive(~f3, ~a, a ^ b ^ 32'h5A5A_5A5A);
    cyc = 0;
    while (!(sel ? if1.done_valid : if0.done_valid) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    t   = sel ? if1.taken : if0.taken;
    lat = sel ? int'(if1.latency) : int'(if0.latency);
  endtask

  task automatic release_result(input bit sel, input string name);
    if (sel) if1.done_ready = 1'b1; else if0.done_ready = 1'b1;
    @(posedge clk); #1;
    if0.done_ready = 1'b0;
    if1.done_ready = 1'b0;
    chk({name, ".done_valid_drop"}, sel ? if1.done_valid : if0.done_valid, 0);
    chk({name, ".start_ready_back"}, sel ? if1.start_ready : if0.start_ready, 1);
  endtask

  task automatic run_vec(input bit sel, input vec_t v, input string name);
    logic t;
    int   lat, cyc;
    issue(sel, v.f3, v.a, v.b, t, lat, cyc);
    chk({name, ".taken"}, t, v.exp_taken);
    chk({name, ".latency"}, lat, v.exp_lat);
    chk({name, ".busy_cycles"}, cyc, v.exp_lat);
    release_result(sel, name);
  endtask

  initial begin
    logic t, t_hold;
    int   lat, cyc, lat_hold;

    v0[0]  = '{3'b000, 32'h0000_000A, 32'h0000_000A, 1'b1, 4};  // beq equal, full scan
    v0[1]  = '{3'b001, 32'h0000_000A, 32'h0000_000A, 1'b0, 4};  // bne equal
    v0[2]  = '{3'b100, 32'hFFFF_FFF6, 32'h0000_0014, 1'b1, 1};  // blt -10 < 20
    v0[3]  = '{3'b101, 32'hFFFF_FFF6, 32'h0000_0014, 1'b0, 1};  // bge
    v0[4]  = '{3'b110, 32'hFFFF_FFF6, 32'h0000_0014, 1'b0, 1};  // bltu
    v0[5]  = '{3'b111, 32'hFFFF_FFF6, 32'h0000_0014, 1'b1, 1};  // bgeu
    v0[6]  = '{3'b111, 32'h1234_5678, 32'h1234_5679, 1'b0, 4};  // last-chunk difference
    v0[7]  = '{3'b100, 32'h1234_5678, 32'h1200_5678, 1'b0, 2};  // decided in chunk 2
    v0[8]  = '{3'b001, 32'h00FF_0000, 32'h00FE_0000, 1'b1, 2};
    v0[9]  = '{3'b110, 32'h0000_0100, 32'h0000_0200, 1'b1, 3};
    v0[10] = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1};  // most negative vs most positive
    v0[11] = '{3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0, 4};  // illegal funct3

    v1[0]  = '{3'b100, 32'hFFFF_FFF6, 32'h0000_0014, 1'b1, 4};
    v1[1]  = '{3'b111, 32'h1234_5678, 32'h1234_5679, 1'b0, 4};
    v1[2]  = '{3'b110, 32'h01FF_FFFF, 32'h0200_0000, 1'b1, 4};  // later chunks must not override

    if0.start_valid = 1'b0; if0.done_ready = 1'b0;
    if1.start_valid = 1'b0; if1.done_ready = 1'b0;
    drive(3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst.start_ready", if0.start_ready, 1);
    chk("rst.done_valid", if0.done_valid, 0);
    chk("rst.taken", if0.taken, 0);
    chk("rst.latency", if0.latency, 0);
    chk("rst.u1_start_ready", if1.start_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(1'b0, v0[i], $sformatf("v0[%0d]", i));
    for (int i = 0; i < 3; i++)  run_vec(1'b1, v1[i], $sformatf("v1[%0d]", i));

    // Backpressure: result must hold while start_valid pulses are ignored.
    issue(1'b0, 3'b110, 32'h0000_0100, 32'h0000_0200, t_hold, lat_hold, cyc);
    chk("bp.taken", t_hold, 1);
    chk("bp.latency", lat_hold, 3);
    for (int i = 0; i < 5; i++) begin
      if0.start_valid = i[0];
      drive(3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("bp[%0d].done_valid", i), if0.done_valid, 1);
      chk($sformatf("bp[%0d].taken", i), if0.taken, t_hold);
      chk($sformatf("bp[%0d].latency", i), if0.latency, lat_hold);
      chk($sformatf("bp[%0d].start_ready", i), if0.start_ready, 0);
    end
    if0.start_valid = 1'b0;
    release_result(1'b0, "bp");
    chk("bp.idle_keeps_taken", if0.taken, t_hold);
    run_vec(1'b0, v0[0], "bp.next");

    // Reset in the second BUSY cycle discards the operation.
    drive(3'b000, 32'h0000_000A, 32'h0000_000A);
    if0.start_valid = 1'b1;
    @(posedge clk); #1;
    if0.start_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid.done_valid", if0.done_valid, 0);
    chk("mid.taken", if0.taken, 0);
    chk("mid.latency", if0.latency, 0);
    chk("mid.start_ready", if0.start_ready, 1);
    repeat (5) @(posedge clk);
    #1 chk("mid.stays_idle", if0.done_valid, 0);

    issue(1'b0, 3'b010, 32'h0, 32'h0, t, lat, cyc);
    chk("f3_010.taken", t, 0);
    chk("f3_010.latency", lat, 4);
    release_result(1'b0, "f3_010");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
